// File: rtl/neuron_weight_seq.sv
// -----------------------------------------------------------------------------
// neuron_weight_seq
//
// Purpose:
//   Sequences the read port of a per-neuron weight ROM that has a 1-cycle
//   registered read. It accepts NUM_WEIGHT activations per frame and issues
//   one ROM read per accepted activation. The activation is delayed by one
//   cycle so that it lines up with its weight. The result is presented to the
//   neuron MAC as {mul_x, mul_w} pairs, with last/done framing.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   start      begin a frame (sampled only in IDLE)
//   in_valid   activation valid
//   in_data    activation value
//   in_ready   activation accepted when in_valid & in_ready (high in RUN)
//   ren        ROM read enable (combinational, = accept)
//   radd       ROM read address (registered counter)
//   wout       ROM read data, valid the cycle after ren
//   mul_valid  {mul_x, mul_w} pair valid
//   mul_x      activation aligned with its weight
//   mul_w      weight (wout, zero when no pair is valid)
//   mul_last   marks the final pair of the frame
//   busy       high in RUN and DRAIN
//   done       one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module neuron_weight_seq #(
  parameter int NUM_WEIGHT = 30,
  // A single-weight neuron still needs a 1-bit address bus.
  parameter int ADDR_W     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ren,
  output logic [ADDR_W-1:0] radd,
  input  logic [DATA_W-1:0] wout,
  output logic              mul_valid,
  output logic [DATA_W-1:0] mul_x,
  output logic [DATA_W-1:0] mul_w,
  output logic              mul_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W-1:0] x_reg;
  logic              v_reg;
  logic              last_reg;
  logic              accept;
  logic              at_last;

  assign in_ready = (state_reg == RUN);
  assign accept   = in_valid & in_ready;
  assign at_last  = (cnt_reg == LAST_IDX);

  // The address comes straight from the counter register. This keeps the
  // combinational path from in_data to the ROM address empty.
  assign ren  = accept;
  assign radd = cnt_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (at_last) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The activation is held for one cycle so that it meets the ROM data for
  // the same index. A gap in the input produces a gap in the output. The
  // stream is never stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      v_reg    <= 1'b0;
      last_reg <= 1'b0;
    end else begin
      v_reg <= accept;
      if (accept) begin
        x_reg    <= in_data;
        last_reg <= at_last;
      end
    end
  end

  assign mul_valid = v_reg;
  assign mul_x     = x_reg;
  // Outside a valid pair the ROM output is stale. While in reset it is not
  // driven by this block at all. Gating it with v_reg therefore gives a
  // clean zero at these times.
  assign mul_w     = v_reg ? wout : '0;
  assign mul_last  = v_reg & last_reg;
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_neuron_weight_seq.sv
module tb_neuron_weight_seq;

  localparam int N  = 30;
  localparam int AW = 5;
  localparam int DW = 16;

  typedef struct {
    logic          start;
    logic          valid;
    logic [DW-1:0] data;
    logic          exp_ready;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic          last;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, ren, mul_valid, mul_last, busy, done;
  logic [AW-1:0] radd;
  logic [DW-1:0] wout = '0;
  logic [DW-1:0] mul_x, mul_w;

  // Signals for the small-N parameter sweep instances
  logic          start2 = 1'b0;
  logic          v2 = 1'b0;
  logic [DW-1:0] d2 = '0;
  logic          a_ready, a_ren, a_valid, a_last, a_busy, a_done;
  logic [0:0]    a_radd;
  logic [DW-1:0] a_wout = '0;
  logic [DW-1:0] a_x, a_w;
  logic          b_ready, b_ren, b_valid, b_last, b_busy, b_done;
  logic [3:0]    b_radd;
  logic [DW-1:0] b_wout = '0;
  logic [DW-1:0] b_x, b_w;

  always #5 clk = ~clk;

  neuron_weight_seq #(.NUM_WEIGHT(N), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ren(ren), .radd(radd),
    .wout(wout), .mul_valid(mul_valid), .mul_x(mul_x), .mul_w(mul_w),
    .mul_last(mul_last), .busy(busy), .done(done)
  );

  neuron_weight_seq #(.NUM_WEIGHT(1), .DATA_W(DW)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(v2),
    .in_data(d2), .in_ready(a_ready), .ren(a_ren), .radd(a_radd),
    .wout(a_wout), .mul_valid(a_valid), .mul_x(a_x), .mul_w(a_w),
    .mul_last(a_last), .busy(a_busy), .done(a_done)
  );

  neuron_weight_seq #(.NUM_WEIGHT(10), .DATA_W(DW)) u_n10 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(v2),
    .in_data(d2), .in_ready(b_ready), .ren(b_ren), .radd(b_radd),
    .wout(b_wout), .mul_valid(b_valid), .mul_x(b_x), .mul_w(b_w),
    .mul_last(b_last), .busy(b_busy), .done(b_done)
  );

  // Weight ROM models with a 1-cycle registered read
  logic [DW-1:0] rom [N];
  always @(posedge clk) if (ren)   wout   <= rom[radd];
  always @(posedge clk) if (a_ren) a_wout <= 16'hA000 + 16'(a_radd);
  always @(posedge clk) if (b_ren) b_wout <= 16'hB000 + 16'(b_radd);

  int     checks = 0;
  int     errors = 0;
  int     n_valid = 0;
  int     n_done = 0;
  int     exp_cnt = 0;
  longint acc_dot = 0;
  pair_t  sb [$];
  pair_t  mon_p;
  vec_t   tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic [DW-1:0] d,
                              input logic r, input logic b, input logic dn);
    vec_t t;
    t.start = s; t.valid = v; t.data = d;
    t.exp_ready = r; t.exp_busy = b; t.exp_done = dn;
    return t;
  endfunction

  // Drive one cycle and check the state-derived outputs. On an expected
  // accept, push the pair that should come out one cycle later.
  task automatic step(input vec_t v);
    pair_t p;
    logic  exp_ren;
    @(negedge clk);
    start = v.start; in_valid = v.valid; in_data = v.data;
    #1;
    exp_ren = v.valid & v.exp_ready;
    chk("in_ready", in_ready, v.exp_ready);
    chk("busy", busy, v.exp_busy);
    chk("done", done, v.exp_done);
    chk("ren", ren, exp_ren);
    if (exp_ren) begin
      chk("radd", radd, exp_cnt);
      p.x = v.data; p.w = rom[exp_cnt]; p.last = (exp_cnt == N - 1);
      sb.push_back(p);
      exp_cnt = (exp_cnt == N - 1) ? 0 : exp_cnt + 1;
    end
    $display("step start=%0b valid=%0b data=%04h ready=%0b radd=%0d", v.start, v.valid, v.data, in_ready, radd);
  endtask

  task automatic run_stream(input int mult, input int base);
    step(mk(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < N; k++)
      step(mk(1'b0, 1'b1, 16'(mult * k + base), 1'b1, 1'b1, 1'b0));
    step(mk(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0));   // DRAIN
    step(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1));   // DONE
  endtask

  // Output monitor: pops the scoreboard on every produced pair
  always @(posedge clk) begin
    #1;
    if (mul_valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair actual mul_x=%0h expected no pair", mul_x);
      end else begin
        mon_p = sb.pop_front();
        chk("mul_x", mul_x, mon_p.x);
        chk("mul_w", mul_w, mon_p.w);
        chk("mul_last", mul_last, mon_p.last);
        acc_dot += longint'(mul_x) * longint'(mul_w);
        $display("pair x=%04h w=%04h last=%0b", mul_x, mul_w, mul_last);
      end
    end else if (rst_n) begin
      chk("mul_last_idle", mul_last, 1'b0);
    end
    if (done === 1'b1) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     c, acc, v0, d0;
    longint ref_dot;

    for (int k = 0; k < N; k++) rom[k] = 16'(k * 1237 + 91);

    // Table for the gapped frame with ignored inputs around and inside it
    tbl.push_back(mk(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0)); // IDLE: valid ignored
    tbl.push_back(mk(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0)); // start+valid: no accept
    c = 0; acc = 0;
    while (acc < N) begin
      tbl.push_back(mk((c == 4) || (c == 9), (c % 3) == 0, 16'(500 + c * 7), 1'b1, 1'b1, 1'b0));
      if ((c % 3) == 0) acc++;
      c++;
    end
    tbl.push_back(mk(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0)); // DRAIN
    tbl.push_back(mk(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b1)); // DONE
    tbl.push_back(mk(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0)); // IDLE again

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ren", ren, 1'b0);
    chk("rst_radd", radd, 0);
    chk("rst_mul_valid", mul_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two streaming frames back-to-back, checked against a reference dot product
    acc_dot = 0; v0 = n_valid; d0 = n_done;
    run_stream(1, 0);
    chk("frameA_done_count", n_done - d0, 1);
    run_stream(3, 1000);
    ref_dot = 0;
    for (int k = 0; k < N; k++)
      ref_dot += longint'(k) * longint'(rom[k]) + longint'(3 * k + 1000) * longint'(rom[k]);
    chk("dot_product", 32'(acc_dot), 32'(ref_dot));
    chk("two_frame_pairs", n_valid - v0, 2 * N);
    chk("two_frame_dones", n_done - d0, 2);

    // Gapped frame with ignored start/in_valid
    v0 = n_valid; d0 = n_done;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    chk("gapped_pairs", n_valid - v0, N);
    chk("gapped_dones", n_done - d0, 1);
    chk("gapped_sb_empty", sb.size(), 0);

    // Reset mid-RUN at cnt=12
    v0 = n_valid; d0 = n_done;
    step(mk(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 12; k++) step(mk(1'b0, 1'b1, 16'(k + 7), 1'b1, 1'b1, 1'b0));
    @(posedge clk);
    #2;
    chk("pre_rst_radd", radd, 12);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_ren", ren, 1'b0);
    chk("arst_radd", radd, 0);
    chk("arst_mul_valid", mul_valid, 1'b0);
    chk("arst_mul_x", mul_x, 0);
    chk("arst_mul_w", mul_w, 0);
    chk("arst_mul_last", mul_last, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    sb.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(5, 3);
    chk("rst_frame_pairs", n_valid - v0, 12 + N);
    chk("rst_frame_dones", n_done - d0, 1);

    // Parameter sweep: NUM_WEIGHT=1 and 10 share one stimulus stream
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    start2 = 1'b1; v2 = 1'b0;
    for (int cy = 1; cy <= 12; cy++) begin
      @(negedge clk);
      start2 = 1'b0; v2 = (cy <= 10); d2 = 16'(49 + cy);
      #1;
      if (cy == 1) begin
        chk("n1_ready", a_ready, 1'b1);
        chk("n1_ren", a_ren, 1'b1);
        chk("n1_radd", a_radd, 0);
      end
      if (cy == 2) begin
        chk("n1_ready_drain", a_ready, 1'b0);
        chk("n1_busy_drain", a_busy, 1'b1);
        chk("n1_valid", a_valid, 1'b1);
        chk("n1_last", a_last, 1'b1);
        chk("n1_x", a_x, 50);
        chk("n1_w", a_w, 16'hA000);
      end
      if (cy == 3) chk("n1_done", a_done, 1'b1);
      if (cy <= 10) begin
        chk("n10_ready", b_ready, 1'b1);
        chk("n10_radd", b_radd, cy - 1);
      end
      if (cy >= 2 && cy <= 10) begin
        chk("n10_valid", b_valid, 1'b1);
        chk("n10_x", b_x, 48 + cy);
        chk("n10_w", b_w, 16'hB000 + cy - 2);
        chk("n10_last_mid", b_last, 1'b0);
      end
      if (cy == 11) begin
        chk("n10_ready_drain", b_ready, 1'b0);
        chk("n10_busy_drain", b_busy, 1'b1);
        chk("n10_radd_wrap", b_radd, 0);
        chk("n10_last", b_last, 1'b1);
        chk("n10_x_last", b_x, 59);
        chk("n10_w_last", b_w, 16'hB009);
      end
      if (cy == 12) chk("n10_done", b_done, 1'b1);
      $display("sweep cy=%0d n1_radd=%0d n10_radd=%0d n10_valid=%0b", cy, a_radd, b_radd, b_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
